// File: rtl/n64_poll_scheduler.sv
// ---------------------------------------------------------------------------
// n64_poll_scheduler
//
// Purpose:
//   Sequences the N64 controller data line. It drives the single-byte
//   command writer and arms the response receiver. After reset it waits one
//   full poll period so the line can settle, then sends identify (0x00).
//   Once a standard controller answers, it sends a poll command (0x01) once
//   per poll period and publishes the latest button/stick word. A controller
//   that misses MAX_MISSES polls in a row is marked absent, and identify
//   starts again.
//
// Ports:
//   clk                 in   1   system clock (100 MHz nominal)
//   reset               in   1   asynchronous, active-high reset
//   cmd_byte            out  8   command byte presented to the writer
//   cmd_en              out  1   writer enable / latch request
//   writing_data        in   1   writer busy flag
//   rx_en               out  1   arms the receiver
//   rx_len              out  6   expected reply length (24 identify, 32 poll)
//   rx_valid            in   1   one-cycle pulse, reply complete
//   rx_word             in   32  reply bits, right-justified
//   buttons             out  32  last good poll reply
//   buttons_valid       out  1   one-cycle pulse when buttons updates
//   controller_present  out  1   link status
//   err_count           out  8   saturating count of failed transactions
// ---------------------------------------------------------------------------
module n64_poll_scheduler #(
  parameter int          POLL_PERIOD      = 1666667,
  parameter int          TX_START_TIMEOUT = 15,
  parameter int          RX_TIMEOUT       = 20000,
  parameter int          MAX_MISSES       = 3,
  parameter logic [15:0] ID_MATCH         = 16'h0500
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  cmd_byte,
  output logic        cmd_en,
  input  logic        writing_data,
  output logic        rx_en,
  output logic [5:0]  rx_len,
  input  logic        rx_valid,
  input  logic [31:0] rx_word,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        controller_present,
  output logic [7:0]  err_count
);

  localparam int TIMER_W = $clog2(POLL_PERIOD + 1);
  localparam int TX_W    = $clog2(TX_START_TIMEOUT + 1);
  localparam int RX_W    = $clog2(RX_TIMEOUT + 1);
  localparam int MISS_W  = $clog2(MAX_MISSES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [TX_W-1:0]    TX_LAST    = TX_W'(TX_START_TIMEOUT - 1);
  localparam logic [RX_W-1:0]    RX_LAST    = RX_W'(RX_TIMEOUT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MAX_MISSES - 1);

  localparam logic [7:0] CMD_ID   = 8'h00;
  localparam logic [7:0] CMD_POLL = 8'h01;
  localparam logic [5:0] LEN_ID   = 6'd24;
  localparam logic [5:0] LEN_POLL = 6'd32;

  typedef enum logic [2:0] {
    RESET_WAIT,
    WAIT_TICK,
    ISSUE,
    WAIT_TX_DONE,
    WAIT_RX,
    CHECK,
    FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TX_W-1:0]    txCnt_q, txCnt_d;
  logic [RX_W-1:0]    rxCnt_q, rxCnt_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               pollMode_q, pollMode_d;
  logic [7:0]         cmdByte_q, cmdByte_d;
  logic               cmdEn_q, cmdEn_d;
  logic               rxEn_q, rxEn_d;
  logic [5:0]         rxLen_q, rxLen_d;
  logic [31:0]        rxData_q, rxData_d;
  logic [31:0]        buttons_q, buttons_d;
  logic               buttonsValid_q, buttonsValid_d;
  logic               present_q, present_d;
  logic [7:0]         errCount_q, errCount_d;

  logic timerWrap;
  logic startCmd;

  assign timerWrap = (timer_q == TIMER_LAST);

  // State and datapath registers. The handshake outputs are registered, so
  // the asynchronous reset drops cmd_en and rx_en right away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RESET_WAIT;
      timer_q        <= '0;
      txCnt_q        <= '0;
      rxCnt_q        <= '0;
      miss_q         <= '0;
      pollMode_q     <= 1'b0;
      cmdByte_q      <= CMD_ID;
      cmdEn_q        <= 1'b0;
      rxEn_q         <= 1'b0;
      rxLen_q        <= LEN_ID;
      rxData_q       <= '0;
      buttons_q      <= '0;
      buttonsValid_q <= 1'b0;
      present_q      <= 1'b0;
      errCount_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      txCnt_q        <= txCnt_d;
      rxCnt_q        <= rxCnt_d;
      miss_q         <= miss_d;
      pollMode_q     <= pollMode_d;
      cmdByte_q      <= cmdByte_d;
      cmdEn_q        <= cmdEn_d;
      rxEn_q         <= rxEn_d;
      rxLen_q        <= rxLen_d;
      rxData_q       <= rxData_d;
      buttons_q      <= buttons_d;
      buttonsValid_q <= buttonsValid_d;
      present_q      <= present_d;
      errCount_q     <= errCount_d;
    end
  end

  // Next-state logic. The period timer runs freely in every state. A new
  // command can begin only when the timer wraps, so a transaction that runs
  // past its period slips to the following wrap.
  always_comb begin
    state_d        = state_q;
    timer_d        = timerWrap ? '0 : timer_q + TIMER_W'(1);
    txCnt_d        = txCnt_q;
    rxCnt_d        = rxCnt_q;
    miss_d         = miss_q;
    pollMode_d     = pollMode_q;
    cmdByte_d      = cmdByte_q;
    cmdEn_d        = cmdEn_q;
    rxEn_d         = rxEn_q;
    rxLen_d        = rxLen_q;
    rxData_d       = rxData_q;
    buttons_d      = buttons_q;
    buttonsValid_d = 1'b0;
    present_d      = present_q;
    errCount_d     = errCount_q;
    startCmd       = 1'b0;

    case (state_q)
      RESET_WAIT: begin
        startCmd = timerWrap;
      end

      WAIT_TICK: begin
        startCmd = timerWrap;
      end

      // cmd_en is low only on the entry cycle. It falls on the edge that
      // first sees the writer busy, so the writer cannot latch the byte a
      // second time when it finishes.
      ISSUE: begin
        if (!cmdEn_q) begin
          cmdEn_d = 1'b1;
        end else if (writing_data) begin
          cmdEn_d = 1'b0;
          state_d = WAIT_TX_DONE;
        end else if (txCnt_q == TX_LAST) begin
          cmdEn_d = 1'b0;
          state_d = FAIL;
        end else begin
          txCnt_d = txCnt_q + TX_W'(1);
        end
      end

      WAIT_TX_DONE: begin
        if (!writing_data) begin
          rxEn_d  = 1'b1;
          rxCnt_d = '0;
          state_d = WAIT_RX;
        end
      end

      // When a reply arrives on the same cycle the timeout expires, the
      // reply wins.
      WAIT_RX: begin
        if (rx_valid) begin
          rxEn_d   = 1'b0;
          rxData_d = rx_word;
          state_d  = CHECK;
        end else if (rxCnt_q == RX_LAST) begin
          rxEn_d  = 1'b0;
          state_d = FAIL;
        end else begin
          rxCnt_d = rxCnt_q + RX_W'(1);
        end
      end

      CHECK: begin
        if (pollMode_q) begin
          buttons_d      = rxData_q;
          buttonsValid_d = 1'b1;
          miss_d         = '0;
          state_d        = WAIT_TICK;
        end else if (rxData_q[23:8] == ID_MATCH) begin
          present_d = 1'b1;
          miss_d    = '0;
          state_d   = WAIT_TICK;
        end else begin
          state_d = FAIL;
        end
      end

      // Only missed polls count toward dropping the link. A failed identify
      // simply waits for the next period and tries again.
      FAIL: begin
        if (errCount_q != 8'hFF) begin
          errCount_d = errCount_q + 8'd1;
        end
        if (pollMode_q) begin
          if (miss_q == MISS_LAST) begin
            present_d = 1'b0;
            miss_d    = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
        state_d = WAIT_TICK;
      end

      default: begin
        state_d = RESET_WAIT;
      end
    endcase

    // Command selection on a timer wrap. Identify is sent until a
    // controller has answered correctly.
    if (startCmd) begin
      state_d    = ISSUE;
      pollMode_d = present_q;
      cmdByte_d  = present_q ? CMD_POLL : CMD_ID;
      rxLen_d    = present_q ? LEN_POLL : LEN_ID;
      txCnt_d    = '0;
    end
  end

  assign cmd_byte           = cmdByte_q;
  assign cmd_en             = cmdEn_q;
  assign rx_en              = rxEn_q;
  assign rx_len             = rxLen_q;
  assign buttons            = buttons_q;
  assign buttons_valid      = buttonsValid_q;
  assign controller_present = present_q;
  assign err_count          = errCount_q;

endmodule
